pad_input_decoder: RTL
======================

// Module: pad_input_decoder
// PURPOSE
//  Master-side reader for a SNES-style serial gamepad (latch/clock/data). Polls the pad periodically
//  and shifts in 16 active-low bits. Maps them to up/down/left/right/attack and emits per-frame
//  pressed/released edge vectors on input_data[9:0] = {pressed[4:0], released[4:0]}.
//  input_data feeds the player logic FSM directly; this block is the producer end of that bus.
// PARAMETERS
//  CLK_DIV      150      clk cycles per pad_clk half-period and per latch half-width; must be >= 4
//  POLL_PERIOD  416667   clk cycles from one latch rise to the next (60 Hz @ 25 MHz); 20-bit counter
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-low reset (0 = reset)
//  pad_data      in   1   serial data from pad; active-low (0 = pressed); asynchronous to clk
//  pad_latch     out  1   latch strobe to pad, active-high
//  pad_clk       out  1   shift clock to pad; idles high
//  input_data    out  10  {pressed[4:0], released[4:0]}; bit order: 0=up 1=down 2=left 3=right 4=attack
//  buttons_held  out  5   current accepted held mask, same bit order
//  frame_valid   out  1   1-cycle pulse, coincident with the input_data update of every completed poll
// BEHAVIOUR
//  Reset values: pad_latch=0, pad_clk=1, input_data=0, buttons_held=0, frame_valid=0; FSM IDLE;
//   poll timer=0. Old/candidate masks=0. Reset mid-transaction aborts immediately; no partial frame emitted.
//  pad_data passes through a 2-flop synchroniser; all sampling uses the synchronised value.
//  FSM: IDLE -> LATCH -> SHIFT -> DONE -> IDLE.
//   IDLE : wait until poll timer == 0; the first poll starts on the first clk after reset release.
//   LATCH: pad_latch=1 for 2*CLK_DIV cycles; pad_clk=1.
//   SHIFT: for bit i = 0..15: pad_clk=1 for CLK_DIV cycles, sample on the last cycle of this phase;
//          then pad_clk=0 for CLK_DIV cycles, except after bit 15. 4-bit bit counter; 16-bit shift register.
//   DONE : 1 cycle. Compute the mask and edges, register the outputs, return to IDLE.
//  Transaction = 33*CLK_DIV + 1 cycles. If POLL_PERIOD is shorter than that, the next LATCH starts
//   on the cycle after DONE (back-to-back). Poll timer reloads to POLL_PERIOD-1 on every LATCH entry.
//  Mapping (raw bit r[k], 0=pressed): up=~r[4], down=~r[5], left=~r[6], right=~r[7],
//   attack=~r[0] | ~r[8] (B or A). Other bits are ignored. Opposing directions are passed through unmasked.
//  Edges vs previously accepted mask old: pressed = new & ~old; released = old & ~new.
//   input_data holds these for exactly one cycle (the cycle after DONE), otherwise 10'b0.
//   buttons_held <= new and old <= new in the same update.
//   A press and a release of different buttons in one frame are both reported in the same cycle.
//  No controller attached (pad_data pulled high) reads as all released; no error flag.
// CONFIGURATION
//  PAD_DEBOUNCE_EN defined: a mask is accepted only when two consecutive frames decode identically.
//   Otherwise the candidate is stored, buttons_held is unchanged, and input_data stays 0.
//   frame_valid still pulses every frame. The candidate register resets to 0.
//  PAD_DEBOUNCE_EN undefined: every frame's decoded mask is accepted immediately.
// STRUCTURE
//  Shared package/header controller_pkg: BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_ATTACK=4;
//   SNES bit indices (SNES_B=0, SNES_UP=4 .. SNES_RIGHT=7, SNES_A=8); FSM state encodings.
//  Sub-module pad_serial_shifter: latch/clock generation, synchroniser, 16-bit capture, done strobe.
//   The top level holds the poll timer, mapping, debounce and edge logic.
// TESTING (CLK_DIV=4, POLL_PERIOD=200 unless noted)
//  Release reset with the pad model idle (all 1s): latch rises next cycle; frame_valid at cycle 133;
//   input_data=0, buttons_held=0.
//  Pad holds Up (r[4]=0) for 2 frames: frame 1 input_data=10'b00001_00000, buttons_held=5'b00001;
//   frame 2 input_data=0.
//  Release Up after a held frame: input_data=10'b00000_00001 for 1 cycle; buttons_held=0.
//  A then B held simultaneously: one pressed pulse on bit 4 only (10'b10000_00000).
//   Dropping A while B is held produces no edge.
//  Assert reset during SHIFT bit 7 with Right held: pad_clk=1, pad_latch=0 immediately.
//   After release, a fresh poll reports pressed=5'b01000.
//  POLL_PERIOD=50: LATCH restarts on the cycle after DONE.
//   With PAD_DEBOUNCE_EN, a Left glitch lasting 1 frame yields no pressed pulse; lasting 2 frames yields one.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared gamepad definitions: logical button indices, SNES serial bit positions,
// shifter FSM states and the raw-to-button mapping.
package controller_pkg;

    localparam int unsigned NUM_BTNS   = 5;
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_ATTACK = 4;

    localparam int unsigned SNES_B     = 0;
    localparam int unsigned SNES_UP    = 4;
    localparam int unsigned SNES_DOWN  = 5;
    localparam int unsigned SNES_LEFT  = 6;
    localparam int unsigned SNES_RIGHT = 7;
    localparam int unsigned SNES_A     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_DONE
    } pad_state_t;

    // Raw bits are active-low; B and A both count as attack.
    function automatic logic [NUM_BTNS-1:0] map_buttons(input logic [15:0] raw);
        logic [NUM_BTNS-1:0] mask;
        mask             = '0;
        mask[BTN_UP]     = ~raw[SNES_UP];
        mask[BTN_DOWN]   = ~raw[SNES_DOWN];
        mask[BTN_LEFT]   = ~raw[SNES_LEFT];
        mask[BTN_RIGHT]  = ~raw[SNES_RIGHT];
        mask[BTN_ATTACK] = ~raw[SNES_B] | ~raw[SNES_A];
        return mask;
    endfunction

endpackage

// File: rtl/pad_serial_shifter.sv
// Pad transaction engine: latch pulse, pad clock generation, pad_data
// synchroniser and 16-bit capture (bit 0 first, stored at raw[0]).
module pad_serial_shifter
    import controller_pkg::*;
#(
    parameter int unsigned CLK_DIV = 150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic        idle,
    output logic        done,
    output logic [15:0] raw
);

    localparam int unsigned CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);

    pad_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          low_q, low_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [1:0]    sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            low_q   <= 1'b0;
            shreg_q <= '1;
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            low_q   <= low_d;
            shreg_q <= shreg_d;
            sync_q  <= {sync_q[0], pad_data};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        low_d   = low_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    low_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!low_q) begin
                        // Sample on the last high cycle; no low phase follows bit 15.
                        shreg_d = {sync_q[1], shreg_q[15:1]};
                        if (bit_q == 4'd15) begin
                            state_d = ST_DONE;
                        end else begin
                            low_d = 1'b1;
                        end
                    end else begin
                        low_d = 1'b0;
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                // A poll already due chains straight into the next latch.
                if (start) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pad_latch = (state_q == ST_LATCH);
    assign pad_clk   = !((state_q == ST_SHIFT) && low_q);
    assign idle      = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign raw       = shreg_q;

endmodule

// File: rtl/pad_input_decoder.sv
// SNES-style gamepad poller producing held mask and per-frame pressed/released edges.
// Optional PAD_DEBOUNCE_EN: accept a mask only after two identical consecutive frames.
module pad_input_decoder
    import controller_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 150,
    parameter int unsigned POLL_PERIOD = 416667
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pad_data,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [9:0]          input_data,
    output logic [NUM_BTNS-1:0] buttons_held,
    output logic                frame_valid
);

    localparam logic [19:0] POLL_RELOAD = 20'(POLL_PERIOD - 1);

    logic [19:0]         timer_q;
    logic                start, idle, done, accept;
    logic [15:0]         raw;
    logic [NUM_BTNS-1:0] new_mask;

    pad_serial_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .rst_n     (reset),
        .start     (start),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .idle      (idle),
        .done      (done),
        .raw       (raw)
    );

    assign start    = (timer_q == '0) && (idle || done);
    assign new_mask = map_buttons(raw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (start) begin
            timer_q <= POLL_RELOAD;
        end else if (timer_q != '0) begin
            timer_q <= timer_q - 20'd1;
        end
    end

`ifdef PAD_DEBOUNCE_EN
    logic [NUM_BTNS-1:0] cand_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q <= '0;
        end else if (done) begin
            cand_q <= new_mask;
        end
    end

    assign accept = done && (new_mask == cand_q);
`else
    assign accept = done;
`endif

    // buttons_held doubles as the previously accepted mask for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            input_data   <= '0;
            buttons_held <= '0;
            frame_valid  <= 1'b0;
        end else begin
            input_data  <= '0;
            frame_valid <= done;
            if (accept) begin
                input_data   <= {new_mask & ~buttons_held, buttons_held & ~new_mask};
                buttons_held <= new_mask;
            end
        end
    end

endmodule
